// File: rtl/r_instr_control.sv
// rtl/r_instr_control.sv - five-cycle fetch/load/decode/execute/writeback instruction controller
//
// Ports
//   clka        in   system clock; all state changes on its rising edge
//   rsta        in   synchronous active-high reset
//   inst_in     in   [31:0] ROM word at the current PC, valid one cycle after the PC moves
//   pc_inc      out  one-cycle pulse in WB that advances the PC by one word
//   ir          out  [31:0] latched instruction register
//   rs_addr     out  [4:0] ir[25:21]
//   rt_addr     out  [4:0] ir[20:16]
//   rd_addr     out  [4:0] ir[15:11]
//   alu_op      out  [2:0] ALU operation, captured at the end of DECODE
//   reg_we      out  register-file write pulse in WB (not for NOP or rd=0)
//   illegal     out  sticky flag for an unsupported instruction
//   halted      out  high while the controller sits in HALT
//   instr_count out  [15:0] retired instructions, saturating at 16'hFFFF

module r_instr_control (
    input  logic        clka,
    input  logic        rsta,
    input  logic [31:0] inst_in,
    output logic        pc_inc,
    output logic [31:0] ir,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  rd_addr,
    output logic [2:0]  alu_op,
    output logic        reg_we,
    output logic        illegal,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LOAD   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       dec_legal;
    logic [2:0] dec_alu;
    logic       is_nop;

    assign rs_addr = ir[25:21];
    assign rt_addr = ir[20:16];
    assign rd_addr = ir[15:11];
    assign is_nop  = (ir == 32'h0);

    // Instruction decode. The all-zero word is a legal NOP that keeps the ADD
    // encoding on alu_op; every other word needs opcode 0 and a known funct.
    always_comb begin
        dec_legal = 1'b0;
        dec_alu   = 3'b010;
        if (is_nop) begin
            dec_legal = 1'b1;
        end else if (ir[31:26] == 6'h00) begin
            case (ir[5:0])
                6'h24:   begin dec_legal = 1'b1; dec_alu = 3'b000; end
                6'h25:   begin dec_legal = 1'b1; dec_alu = 3'b001; end
                6'h20:   begin dec_legal = 1'b1; dec_alu = 3'b010; end
                6'h26:   begin dec_legal = 1'b1; dec_alu = 3'b011; end
                6'h27:   begin dec_legal = 1'b1; dec_alu = 3'b100; end
                6'h22:   begin dec_legal = 1'b1; dec_alu = 3'b110; end
                6'h2A:   begin dec_legal = 1'b1; dec_alu = 3'b111; end
                default: begin dec_legal = 1'b0; dec_alu = 3'b010; end
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_DECODE;
            S_DECODE: state_nxt = dec_legal ? S_EXEC : S_HALT;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Strobes are gated by rsta so a reset landing in WB kills that cycle's
    // pulses rather than letting them escape for one last cycle.
    always_comb begin
        pc_inc = (state == S_WB) && !rsta;
        reg_we = (state == S_WB) && !rsta && !is_nop && (rd_addr != 5'd0);
        halted = (state == S_HALT);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            ir          <= 32'h0;
            alu_op      <= 3'b000;
            illegal     <= 1'b0;
            instr_count <= 16'h0;
        end else begin
            case (state)
                S_LOAD: ir <= inst_in;
                S_DECODE: begin
                    if (dec_legal) begin
                        alu_op <= dec_alu;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                S_WB: begin
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
